// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and hazard/forward response bundle for pipe_hazard_ctrl.
// Optional perf counters (PIPE_PERF_CNT_EN) ride on the same bundle.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3
);
  localparam int FWD_W = $clog2(NUM_STAGES);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_is_branch;
  logic              id_br_taken;
  logic              mem_ready;

  logic              stall_if_id;
  logic              bubble_ex;
  logic              flush_if_id;
  logic [FWD_W-1:0]  fwd_a;
  logic [FWD_W-1:0]  fwd_b;
  logic [1:0]        pipe_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       memw_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
           id_reg_write, id_mem_read, id_is_branch, id_br_taken, mem_ready,
`ifdef PIPE_PERF_CNT_EN
    input  stall_cnt, memw_cnt,
`endif
    input  stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, pipe_state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
           id_reg_write, id_mem_read, id_is_branch, id_br_taken, mem_ready,
`ifdef PIPE_PERF_CNT_EN
    output stall_cnt, memw_cnt,
`endif
    output stall_if_id, bubble_ex, flush_if_id, fwd_a, fwd_b, pipe_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the MIPS pipeline; shadows in-flight writes.
// Define PIPE_PERF_CNT_EN to add HAZ/MEMW cycle counters (stall_cnt, memw_cnt).
module pipe_hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int NUM_STAGES     = 3,
  parameter int LOAD_READY_STG = 2
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int FWD_W = $clog2(NUM_STAGES);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HAZ  = 2'd1,
    ST_MEMW = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wr;
    logic              ld;
  } slot_t;

  slot_t             slots [NUM_STAGES];
  logic [REG_AW-1:0] ex_rs, ex_rt;
  state_e            state_q, state_d;
  logic              load_use, br_hit, haz;
  logic [FWD_W-1:0]  fwd_a_d, fwd_b_d;

  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.wr & (s.dest == r) & (r != '0);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_use = 1'b0;
    br_hit   = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if ((k + 1 < LOAD_READY_STG) && slots[k].ld) begin
        if (bus.id_use_rs && writes(slots[k], bus.id_rs)) load_use = 1'b1;
        if (bus.id_use_rt && writes(slots[k], bus.id_rt)) load_use = 1'b1;
      end
      // WB slot is excluded: the register file writes before ID reads.
      if (k <= NUM_STAGES - 2) begin
        if (bus.id_use_rs && writes(slots[k], bus.id_rs)) br_hit = 1'b1;
        if (bus.id_use_rt && writes(slots[k], bus.id_rt)) br_hit = 1'b1;
      end
    end
    haz = bus.id_valid & (load_use | (bus.id_is_branch & br_hit));
  end

  always_comb begin
    state_d = ST_RUN;
    if (!bus.mem_ready) state_d = ST_MEMW;
    else if (haz)       state_d = ST_HAZ;
  end

  // Gated by reset so a stall drops the instant reset asserts, even with mem_ready low.
  assign bus.stall_if_id = reset & (state_d != ST_RUN);
  assign bus.bubble_ex   = reset & (state_d == ST_HAZ);
  assign bus.flush_if_id = reset & (state_d == ST_RUN) & bus.id_valid
                         & bus.id_is_branch & bus.id_br_taken;

  // Scan oldest to youngest so the nearest producer overwrites older ones.
  always_comb begin
    fwd_a_d = '0;
    fwd_b_d = '0;
    if (slots[0].valid) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        if (writes(slots[k], ex_rs)) fwd_a_d = FWD_W'(k);
        if (writes(slots[k], ex_rt)) fwd_b_d = FWD_W'(k);
      end
    end
  end

  assign bus.fwd_a      = fwd_a_d;
  assign bus.fwd_b      = fwd_b_d;
  assign bus.pipe_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // NOTE: the slot array is control state, not a datapath RAM, so every entry is reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) slots[k] <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
    end else if (state_d != ST_MEMW) begin
      for (int k = 1; k < NUM_STAGES; k++) slots[k] <= slots[k-1];
      if (state_d == ST_HAZ) begin
        slots[0] <= '0;
      end else begin
        slots[0] <= '{valid: bus.id_valid, dest: bus.id_dest,
                      wr: bus.id_reg_write, ld: bus.id_mem_read};
        ex_rs    <= bus.id_rs;
        ex_rt    <= bus.id_rt;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, memw_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      memw_cnt_q  <= '0;
    end else begin
      if (state_d == ST_HAZ)  stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_d == ST_MEMW) memw_cnt_q  <= memw_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.memw_cnt  = memw_cnt_q;
`endif
endmodule
